// File: rtl/mul_seq_ctrl_pkg.sv
// Shared CPU definitions used by the multiply sequencer and decode.
package mul_seq_ctrl_pkg;

  // Sequencer state encoding; code 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_WB   = 2'b10
  } mul_state_e;

  // Opcode that decode turns into the one-cycle start pulse.
  localparam logic [3:0] OPC_MUL = 4'b1101;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand, partial-product high half,
// and multiplier/low-half shift register. The FSM sequences it.
module mul_shift_add_dp #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W:0]   w_sum;

  // Conditional add of the multiplicand; the extra bit keeps the carry.
  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  end

  // Operand capture on load, one add/shift per step; carry lands in hi MSB.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_load) begin
      r_mcand <= op_a;
      r_hi    <= '0;
      r_lo    <= op_b;
    end else if (i_step) begin
      r_hi <= w_sum[DATA_W:1];
      r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative multiply sequencer: stalls the front end, runs DATA_W
// add/shift steps, then writes the product back to registers A and B.
//
//   state | meaning
//   IDLE  | waiting for start; stall mirrors start
//   CALC  | one add/shift per cycle, DATA_W cycles
//   WB    | one-cycle write-back of {hi,lo}; pipeline resumes next cycle
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              load_A,
  output logic              load_B,
  output logic [DATA_W-1:0] prod_lo,
  output logic [DATA_W-1:0] prod_hi
);

  mul_state_e        r_state;
  mul_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_load;
  logic              w_step;
  logic              w_stall;
  logic              w_busy;
  logic              w_done;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Iteration counter: cleared on operand load, advanced per step.
  always_ff @(posedge clock) begin
    if (reset)       r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Next-state and control decode; abort suppresses write-back immediately.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_stall     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = start;
        if (start && !abort) begin
          w_load      = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_stall = 1'b1;
        w_busy  = 1'b1;
        if (!abort) begin
          w_step      = 1'b1;
          w_state_nxt = w_last ? ST_WB : ST_CALC;
        end
      end
      ST_WB: begin
        w_stall = 1'b1;
        w_busy  = 1'b1;
        w_done  = !abort;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mul_shift_add_dp #(.DATA_W(DATA_W)) u_dp (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .op_a   (op_a),
    .op_b   (op_b),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  assign stall   = w_stall;
  assign busy    = w_busy;
  assign done    = w_done;
  assign load_A  = w_done;
  assign load_B  = w_done;
  assign prod_lo = w_done ? w_lo : '0;
  assign prod_hi = w_done ? w_hi : '0;

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative shift-add multiply sequencer for the 4-bit CPU.
- Decode issues a MUL as a one-cycle `start` carrying both operands (A and B register contents). The block stalls fetch/decode, runs DATA_W add/shift cycles, then writes the 2·DATA_W-bit product back: low half to register A, high half to register B.
- It replaces the single-cycle MUL path in the ALU mux and sits beside the ALU decode controller.

Parameters:
- DATA_W, 4, operand width in bits; product is 2*DATA_W bits.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  MUL decoded this cycle; operands valid. Sampled only in IDLE.
- abort  in  1  synchronous cancel, e.g. pipeline flush. Discards the in-flight multiply.
- op_a  in  DATA_W  multiplicand (register A).
- op_b  in  DATA_W  multiplier (register B).
- stall  out  1  holds fetch/decode: PC and instruction register must not advance.
- busy  out  1  high in CALC or WB.
- done  out  1  one-cycle pulse in WB.
- load_A  out  1  write strobe for register A (= done).
- load_B  out  1  write strobe for register B (= done).
- prod_lo  out  DATA_W  product bits [DATA_W-1:0]; valid when done=1.
- prod_hi  out  DATA_W  product bits [2*DATA_W-1:DATA_W]; valid when done=1.

Behaviour:
- Reset: reset=1 at a rising edge forces state=IDLE and clears mcand, hi, lo and cnt to 0. While in IDLE all outputs are 0, except stall, which follows start.
- State encoding: IDLE, CALC, WB. The state register is 2 bits; the unused code returns to IDLE on the next edge.
- IDLE:
  - stall = start (combinational), so the instruction after MUL is frozen in the same cycle.
  - On start=1 and abort=0: mcand<=op_a, lo<=op_b, hi<=0, cnt<=0, go to CALC.
- CALC, per cycle:
  - sum (DATA_W+1 bits) = {0,hi} + (lo[0] ? {0,mcand} : 0).
  - {hi,lo} <= {sum,lo} >> 1; cnt <= cnt+1.
  - When cnt==DATA_W-1, go to WB.
  - stall=1, busy=1.
- WB:
  - done=load_A=load_B=1; prod_lo=lo, prod_hi=hi; stall=1, busy=1.
  - Next state IDLE. stall drops the following cycle, so the pipeline resumes one cycle after write-back.
- Latency:
  - start sampled at edge t; CALC occupies edges t+1 .. t+DATA_W; done is high during the cycle after edge t+DATA_W.
  - Fixed at DATA_W+2 cycles from the start cycle through the WB cycle, independent of operand values. No early termination.
- Width rules: unsigned operands only. The carry bit of sum is shifted into hi[DATA_W-1], so no overflow is possible.
- start while busy: ignored and not queued. The stall guarantees decode cannot legally issue it.
- abort:
  - In CALC or WB: next state IDLE; done/load_A/load_B are forced to 0 in that same cycle, so there is no write-back.
  - In IDLE with start: start is ignored.
- Simultaneous reset and abort/start: reset wins.
- Reset mid-operation: IDLE on the next edge, no write-back, product discarded.
- Outputs prod_lo/prod_hi are 0 whenever done=0.
- No combinational path from op_a/op_b to any output.

Decomposition:
- Shared CPU package holds:
  - state encoding constants (IDLE=2'b00, CALC=2'b01, WB=2'b10);
  - the MUL opcode constant (4'b1101) used by decode to form `start`.
- One natural sub-module: mul_shift_add_dp. It contains the mcand/hi/lo registers and the adder, controlled by load and step enables from the FSM.
- The FSM and counter stay in mul_seq_ctrl.

Test Plan:
- Reset, then start with op_a=7, op_b=5 → stall in the start cycle; done is high 5 cycles later (DATA_W+1) with prod_hi=4'h2, prod_lo=4'h3 (35); stall is low the next cycle.
- op_a=15, op_b=15 → prod_hi=4'hE, prod_lo=4'h1 (225). Checks carry into hi MSB.
- op_a=0, op_b=9, then op_a=9, op_b=0 → both products 0; latency is still 6 cycles from start cycle to done cycle.
- start with 6×3, then start pulsed again during CALC with 2×2 → single done with 18 (hi=1, lo=2); no second done.
- abort asserted on the 2nd CALC cycle → IDLE next cycle; done/load_A/load_B never rise. Then start with 3×3 → 9, normal latency.
- reset asserted during WB → done forced low from the next edge, state IDLE, all outputs 0; abort+reset together behave as reset.
